// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//
// Control-path instruction sequencer. It fetches 8-bit packets from a
// synchronous instruction ROM and decodes the four control opcodes:
//   EXECUTE (0000): hand instr[7:4] to the execute unit over valid/ready,
//                   then advance pc.
//   JUMP    (0100): pc <= instr[7:4].
//   CALL    (1000): push pc+1 on the return stack, then pc <= instr[7:4].
//   RETURN  (1100): pop the return stack into pc.
// Every other opcode, a CALL with a full stack, and a RETURN with an empty
// stack all end in a sticky FAULT state that only rst leaves.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   start             one-cycle pulse, begins fetching from pc when idle
//   imem_addr/imem_rd fetch address and strobe (ROM answers the next cycle)
//   imem_data         instruction packet: [7:4] operand/target, [3:0] opcode
//   exec_valid/exec_data/exec_ready  operand handshake to the execute unit
//   pc, sp            program counter and return-stack occupancy
//   busy              high in every state except IDLE
//   fault, fault_code sticky error flag; 01 overflow, 10 underflow,
//                     11 illegal opcode
// -----------------------------------------------------------------------------
module instr_sequencer #(
  parameter int ADDR_W      = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd,
  input  logic [7:0]        imem_data,
  output logic              exec_valid,
  output logic [3:0]        exec_data,
  input  logic              exec_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        sp,
  output logic              busy,
  output logic              fault,
  output logic [1:0]        fault_code
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [3:0]        OP_EXECUTE = 4'b0000;
  localparam logic [3:0]        OP_JUMP    = 4'b0100;
  localparam logic [3:0]        OP_CALL    = 4'b1000;
  localparam logic [3:0]        OP_RETURN  = 4'b1100;
  localparam logic [3:0]        DEPTH4     = 4'(STACK_DEPTH);
  localparam logic [ADDR_W-1:0] PC_ONE     = ADDR_W'(1);

  localparam logic [1:0] FC_OVERFLOW  = 2'b01;
  localparam logic [1:0] FC_UNDERFLOW = 2'b10;
  localparam logic [1:0] FC_ILLEGAL   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t state;

  // Return stack and latched operand are pure data: no reset needed.
  logic [ADDR_W-1:0] stack [STACK_DEPTH];
  logic [3:0]        operand_q;

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_inc;
  logic [3:0]        sp_dec;
  logic              stack_full;
  logic              stack_empty;
  logic              push;
  logic [ADDR_W-1:0] ret_addr;

  always_comb begin
    opcode      = imem_data[3:0];
    // Target bits above ADDR_W-1 are dropped when ADDR_W < 4.
    target      = imem_data[4 +: ADDR_W];
    // Wraps modulo 2^ADDR_W; the pushed return address wraps the same way.
    pc_inc      = pc + PC_ONE;
    sp_dec      = sp - 4'd1;
    stack_full  = (sp >= DEPTH4);
    stack_empty = (sp == 4'd0);
    push        = (state == S_DECODE) && (opcode == OP_CALL) && !stack_full;
    ret_addr    = stack[sp_dec[IDX_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      stack[sp[IDX_W-1:0]] <= pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_DECODE) begin
      operand_q <= imem_data[7:4];
    end
  end

  // Operand is only meaningful while the handshake is open; zero otherwise.
  assign exec_data = exec_valid ? operand_q : 4'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= '0;
      sp         <= 4'd0;
      imem_addr  <= '0;
      imem_rd    <= 1'b0;
      exec_valid <= 1'b0;
      busy       <= 1'b0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
    end else begin
      // The fetch strobe lasts exactly the FETCH cycle.
      imem_rd <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_FETCH;
            imem_addr <= pc;
            imem_rd   <= 1'b1;
            busy      <= 1'b1;
          end
        end

        S_FETCH: begin
          state <= S_DECODE;
        end

        S_DECODE: begin
          case (opcode)
            OP_EXECUTE: begin
              state      <= S_EXEC;
              exec_valid <= 1'b1;
            end
            OP_JUMP: begin
              state     <= S_FETCH;
              pc        <= target;
              imem_addr <= target;
              imem_rd   <= 1'b1;
            end
            OP_CALL: begin
              if (stack_full) begin
                state      <= S_FAULT;
                fault      <= 1'b1;
                fault_code <= FC_OVERFLOW;
              end else begin
                state     <= S_FETCH;
                sp        <= sp + 4'd1;
                pc        <= target;
                imem_addr <= target;
                imem_rd   <= 1'b1;
              end
            end
            OP_RETURN: begin
              if (stack_empty) begin
                state      <= S_FAULT;
                fault      <= 1'b1;
                fault_code <= FC_UNDERFLOW;
              end else begin
                state     <= S_FETCH;
                sp        <= sp_dec;
                pc        <= ret_addr;
                imem_addr <= ret_addr;
                imem_rd   <= 1'b1;
              end
            end
            default: begin
              state      <= S_FAULT;
              fault      <= 1'b1;
              fault_code <= FC_ILLEGAL;
            end
          endcase
        end

        S_EXEC: begin
          // exec_valid stays high until the execute unit takes the operand.
          if (exec_ready) begin
            state      <= S_FETCH;
            exec_valid <= 1'b0;
            pc         <= pc_inc;
            imem_addr  <= pc_inc;
            imem_rd    <= 1'b1;
          end
        end

        S_FAULT: begin
          // Sticky: everything frozen until rst.
          state <= S_FAULT;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Instruction sequencer for the custom processor control path. It fetches 8-bit instruction packets from a synchronous instruction ROM and decodes the four control opcodes: EXECUTE, JUMP, CALL and RETURN. It owns the program counter and the hardware return-address stack. EXECUTE operands go to the execute unit over a valid/ready handshake; stack overflow, stack underflow and illegal opcodes end in a sticky fault state.

## Interface
- ADDR_W, 4, program counter / instruction address width
- STACK_DEPTH, 4, return-stack entries (1..8)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins fetching from the current pc when idle
- imem_addr  out  ADDR_W  instruction fetch address
- imem_rd  out  1  fetch strobe; ROM returns data on the following cycle
- imem_data  in  8  instruction packet: [7:4] operand/target, [3:0] opcode
- exec_valid  out  1  operand available to the execute unit
- exec_data  out  4  operand (instr[7:4]) for the execute unit
- exec_ready  in  1  execute unit accepts the operand
- pc  out  ADDR_W  current program counter
- sp  out  4  stack occupancy, 0..STACK_DEPTH
- busy  out  1  high in every state except IDLE
- fault  out  1  sticky error flag
- fault_code  out  2  01 overflow, 10 underflow, 11 illegal opcode, 00 none

## Operation
- Opcodes in instr[3:0]: 0000 EXECUTE, 0100 JUMP, 1000 CALL, 1100 RETURN. Every other value is illegal.
- FSM states: IDLE, FETCH, DECODE, EXEC, FAULT.
- IDLE: outputs quiescent. start=1 -> FETCH.
- FETCH: imem_addr=pc, imem_rd=1 for exactly this cycle -> DECODE.
- DECODE: latch imem_data into an internal instr register, then act on the opcode:
  - EXECUTE -> EXEC.
  - JUMP: pc<=instr[7:4] -> FETCH.
  - CALL, sp<STACK_DEPTH: stack[sp]<=pc+1 (mod 2^ADDR_W), sp<=sp+1, pc<=instr[7:4] -> FETCH.
  - CALL, sp==STACK_DEPTH: fault_code=01 -> FAULT. pc and stack unchanged.
  - RETURN, sp>0: pc<=stack[sp-1], sp<=sp-1 -> FETCH.
  - RETURN, sp==0: fault_code=10 -> FAULT.
  - Illegal opcode: fault_code=11 -> FAULT.
- EXEC: exec_valid=1, exec_data=instr[7:4] held stable. On the cycle with exec_valid & exec_ready: pc<=pc+1 -> FETCH. exec_valid must not drop before the handshake.
- FAULT: fault=1, fault_code held, pc/sp frozen, no fetches, start ignored. Only rst exits.
- start outside IDLE is ignored. There is no self-return to IDLE; the program loops via JUMP.
- pc arithmetic wraps modulo 2^ADDR_W: 15+1 -> 0. The stored return address wraps the same way.
- JUMP and CALL ignore instr[7:4] bits above ADDR_W-1 when ADDR_W<4. pc, imem_addr and the stack are zero-extended to 4 bits internally when ADDR_W<4.

## Timing
- Reset values: pc=0, sp=0, imem_addr=0, imem_rd=0, exec_valid=0, exec_data=0, busy=0, fault=0, fault_code=0, state IDLE. Stack contents are don't-care.
- rst asserted in any state, including mid-handshake, returns to reset values immediately. An in-flight operand is discarded.
- start at edge N -> FETCH in cycle N+1 -> DECODE in N+2.
- JUMP, CALL, RETURN: 2 cycles each (FETCH, DECODE). The next fetch uses the new pc.
- EXECUTE: minimum 3 cycles (FETCH, DECODE, EXEC with exec_ready=1). Each cycle of exec_ready=0 adds one cycle.
- exec_ready high outside EXEC has no effect.
- fault and fault_code assert in the cycle after DECODE of the offending instruction. busy stays 1 while in FAULT.
- All outputs are registered or decoded from registered state only. There is no combinational path from exec_ready or imem_data to any output.

## Test plan
- Reset, then start; ROM[0]=0x30 (EXECUTE op 3), exec_ready=1 -> exec_valid in cycle 3 with exec_data=3, pc=1 next cycle, fetch of address 1.
- EXEC backpressure: exec_ready low for 4 cycles -> exec_valid and exec_data held stable, pc unchanged until the handshake, then pc+1.
- CALL/RETURN: ROM[0]=0x58 (CALL 5), ROM[5]=0x0C (RETURN) -> pc 0 -> 5 -> 1, sp 0 -> 1 -> 0.
- Overflow: chain of 5 nested CALLs with STACK_DEPTH=4 -> fault=1, fault_code=01, sp=4, pc equals the address of the fifth CALL, imem_rd stays 0 afterwards.
- Underflow and illegal opcode: RETURN with sp=0 -> fault_code=10. Packet 0x01 -> fault_code=11. In both cases start is ignored and rst clears all outputs.
- Wrap: JUMP to 15 where ROM[15] is EXECUTE -> after the handshake pc=0. rst asserted during EXEC -> exec_valid drops asynchronously and pc=0.
